eu_wakeup_issue_queue: RTL and testbench

Parametrised, out-of-order-capable instruction queue for one execution unit, successor to the in-order EU instruction queue. It holds dispatched instructions together with per-operand ready bits. It snoops several interconnect wakeup channels to mark operands ready, and issues the oldest fully-ready entry to the ALU over a valid/ready handshake. It sits between backend dispatch and the EU ALU/cache pair.

---
 rtl/eu_wakeup_issue_queue.sv | 134 +++++++++++++
 tb/tb_eu_wakeup_issue_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/eu_wakeup_issue_queue.sv
// rtl/eu_wakeup_issue_queue.sv - oldest-first wakeup/select issue queue for one execution unit
module eu_wakeup_issue_queue #(
    parameter int LOG2_DEPTH = 2,
    parameter int NUM_OPS    = 2,
    parameter int NUM_WAKE   = 2,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush_i,
    input  logic                        disp_valid_i,
    input  logic [PAYLOAD_W-1:0]        disp_payload_i,
    input  logic [NUM_OPS*TAG_W-1:0]    disp_tag_i,
    input  logic [NUM_OPS-1:0]          disp_opd_ready_i,
    output logic                        disp_ready_o,
    input  logic [NUM_WAKE-1:0]         wake_valid_i,
    input  logic [NUM_WAKE*TAG_W-1:0]   wake_tag_i,
    output logic                        issue_valid_o,
    output logic [PAYLOAD_W-1:0]        issue_payload_o,
    input  logic                        issue_ready_i,
    output logic [LOG2_DEPTH:0]         count_o
);
    localparam int DEPTH = 2**LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam int TW    = NUM_OPS * TAG_W;

    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [TW-1:0]        tag_q     [DEPTH];
    logic [TW-1:0]        tag_d     [DEPTH];
    logic [NUM_OPS-1:0]   rdy_q     [DEPTH];
    logic [NUM_OPS-1:0]   rdy_d     [DEPTH];
    logic [CW-1:0]        count_q, count_d;

    logic          any_ready;
    logic [CW-1:0] sel;
    logic          issue_fire;
    logic          disp_fire;
    logic [CW-1:0] wr_idx;

    // Ready bits of an operand group after OR-ing in every matching wakeup channel.
    function automatic logic [NUM_OPS-1:0] wake_ops(
        input logic [TW-1:0]             tags,
        input logic [NUM_OPS-1:0]        rdy,
        input logic [NUM_WAKE-1:0]       wv,
        input logic [NUM_WAKE*TAG_W-1:0] wt
    );
        logic [NUM_OPS-1:0] r;
        r = rdy;
        for (int k = 0; k < NUM_OPS; k++) begin
            for (int w = 0; w < NUM_WAKE; w++) begin
                if (wv[w] && (wt[w*TAG_W +: TAG_W] == tags[k*TAG_W +: TAG_W])) begin
                    r[k] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Slot 0 is oldest, so scanning downward leaves the lowest-index ready slot selected.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count_q) && (&rdy_q[i])) begin
                any_ready = 1'b1;
                sel       = CW'(i);
            end
        end
        issue_payload_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (any_ready && (CW'(i) == sel)) begin
                issue_payload_o = payload_q[i];
            end
        end
    end

    assign issue_valid_o = any_ready;
    assign disp_ready_o  = (count_q != CW'(DEPTH));
    assign count_o       = count_q;
    assign issue_fire    = any_ready && issue_ready_i;
    assign disp_fire     = disp_valid_i && disp_ready_o;
    assign wr_idx        = count_q - CW'(issue_fire);

    always_comb begin
        payload_d = payload_q;
        tag_d     = tag_q;
        rdy_d     = rdy_q;
        count_d   = count_q;
        // Slots at and above the issued one take their upper neighbour, wakeups included.
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && (CW'(i) >= sel)) begin
                payload_d[i] = payload_q[(i + 1) % DEPTH];
                tag_d[i]     = tag_q[(i + 1) % DEPTH];
                rdy_d[i]     = wake_ops(tag_q[(i + 1) % DEPTH], rdy_q[(i + 1) % DEPTH],
                                        wake_valid_i, wake_tag_i);
            end else begin
                rdy_d[i]     = wake_ops(tag_q[i], rdy_q[i], wake_valid_i, wake_tag_i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && (CW'(i) == wr_idx)) begin
                payload_d[i] = disp_payload_i;
                tag_d[i]     = disp_tag_i;
                rdy_d[i]     = wake_ops(disp_tag_i, disp_opd_ready_i, wake_valid_i, wake_tag_i);
            end
        end
        case ({disp_fire, issue_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                tag_q[i]     <= '0;
                rdy_q[i]     <= '0;
            end
        end else begin
            count_q   <= count_d;
            payload_q <= payload_d;
            tag_q     <= tag_d;
            rdy_q     <= rdy_d;
        end
    end
endmodule

// File: tb/tb_eu_wakeup_issue_queue.sv
// tb/tb_eu_wakeup_issue_queue.sv - directed and random checks of eu_wakeup_issue_queue against a queue model
module tb_eu_wakeup_issue_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush_i;
    logic        disp_valid_i;
    logic [31:0] disp_payload_i;
    logic [11:0] disp_tag_i;
    logic [1:0]  disp_opd_ready_i;
    logic        disp_ready_o;
    logic [1:0]  wake_valid_i;
    logic [11:0] wake_tag_i;
    logic        issue_valid_o;
    logic [31:0] issue_payload_o;
    logic        issue_ready_i;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    eu_wakeup_issue_queue #(
        .LOG2_DEPTH(2), .NUM_OPS(2), .NUM_WAKE(2), .TAG_W(6), .PAYLOAD_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_payload_i(disp_payload_i),
        .disp_tag_i(disp_tag_i), .disp_opd_ready_i(disp_opd_ready_i),
        .disp_ready_o(disp_ready_o), .wake_valid_i(wake_valid_i),
        .wake_tag_i(wake_tag_i), .issue_valid_o(issue_valid_o),
        .issue_payload_o(issue_payload_o), .issue_ready_i(issue_ready_i),
        .count_o(count_o)
    );

    typedef struct packed {
        logic [31:0] p;
        logic [11:0] t;
        logic [1:0]  r;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [5:0] t);
        return (wake_valid_i[0] && wake_tag_i[5:0] == t) || (wake_valid_i[1] && wake_tag_i[11:6] == t);
    endfunction

    function automatic int model_sel();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].r == 2'b11) return j;
        end
        return -1;
    endfunction

    task automatic check_model();
        int s;
        s = model_sel();
        chk("issue_valid", 32'(issue_valid_o), 32'(s >= 0));
        if (s >= 0) chk("issue_payload", issue_payload_o, q[s].p);
        else        chk("issue_payload_idle", issue_payload_o, 32'h0);
        chk("count", 32'(count_o), 32'(q.size()));
        chk("disp_ready", 32'(disp_ready_o), 32'(q.size() != DEPTH));
    endtask

    task automatic model_update();
        int   s;
        logic fi, fd;
        ent_t e;
        s  = model_sel();
        fi = (s >= 0) && issue_ready_i;
        fd = disp_valid_i && (q.size() < DEPTH);
        if (flush_i) begin
            q.delete();
            return;
        end
        for (int j = 0; j < q.size(); j++) begin
            e = q[j];
            for (int k = 0; k < 2; k++) if (hit(e.t[k*6 +: 6])) e.r[k] = 1'b1;
            q[j] = e;
        end
        if (fi) q.delete(s);
        if (fd) begin
            e.p = disp_payload_i;
            e.t = disp_tag_i;
            for (int k = 0; k < 2; k++) e.r[k] = disp_opd_ready_i[k] | hit(disp_tag_i[k*6 +: 6]);
            q.push_back(e);
        end
    endtask

    task automatic step();
        check_model();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic dv, input logic [31:0] p, input logic [5:0] t1, input logic [5:0] t0,
                         input logic [1:0] r, input logic [1:0] wv, input logic [5:0] w1,
                         input logic [5:0] w0, input logic ir);
        flush_i          = 1'b0;
        disp_valid_i     = dv;
        disp_payload_i   = p;
        disp_tag_i       = {t1, t0};
        disp_opd_ready_i = r;
        wake_valid_i     = wv;
        wake_tag_i       = {w1, w0};
        issue_ready_i    = ir;
    endtask

    task automatic idle(input logic ir);
        drive(1'b0, 32'h0, 6'd0, 6'd0, 2'b00, 2'b00, 6'd0, 6'd0, ir);
    endtask

    initial begin
        reset_n = 1'b0;
        idle(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(issue_valid_o), 32'h0);
        chk("rst_payload", issue_payload_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_disp_ready", 32'(disp_ready_o), 32'h1);
        reset_n = 1'b1;
        @(negedge clk);

        drive(1'b1, 32'hA1, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1); step();
        idle(1'b1);
        chk("basic_valid", 32'(issue_valid_o), 32'h1);
        chk("basic_payload", issue_payload_o, 32'hA1);
        chk("basic_count", 32'(count_o), 32'h1);
        step();
        chk("basic_drained", 32'(count_o), 32'h0);

        drive(1'b1, 32'hA, 6'd6, 6'd5, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0); step();
        drive(1'b1, 32'hB, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1); step();
        idle(1'b1);
        chk("ooo_b_first", issue_payload_o, 32'hB);
        step();
        drive(1'b0, 32'h0, 6'd0, 6'd0, 2'b00, 2'b01, 6'd0, 6'd5, 1'b1); step();
        chk("ooo_a_blocked", 32'(issue_valid_o), 32'h0);
        drive(1'b0, 32'h0, 6'd0, 6'd0, 2'b00, 2'b10, 6'd6, 6'd0, 1'b1); step();
        idle(1'b1);
        chk("ooo_a_issue", issue_payload_o, 32'hA);
        step();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0); step();
        end
        chk("full_disp_ready", 32'(disp_ready_o), 32'h0);
        chk("full_count", 32'(count_o), 32'h4);
        drive(1'b1, 32'hD0, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0); step();
        chk("full_hold_count", 32'(count_o), 32'h4);
        drive(1'b1, 32'hD0, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1);
        chk("drain_0", issue_payload_o, 32'hC0);
        step();
        chk("refill_ready", 32'(disp_ready_o), 32'h1);
        chk("drain_1", issue_payload_o, 32'hC1);
        step();
        idle(1'b1);
        chk("drain_2", issue_payload_o, 32'hC2); step();
        chk("drain_3", issue_payload_o, 32'hC3); step();
        chk("drain_d", issue_payload_o, 32'hD0); step();
        chk("drain_empty", 32'(count_o), 32'h0);

        drive(1'b1, 32'h99, 6'd0, 6'd9, 2'b10, 2'b10, 6'd9, 6'd0, 1'b0); step();
        idle(1'b1);
        chk("bypass_valid", 32'(issue_valid_o), 32'h1);
        chk("bypass_payload", issue_payload_o, 32'h99);
        step();

        drive(1'b1, 32'hE0, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0); step();
        drive(1'b1, 32'hE1, 6'd7, 6'd7, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0); step();
        drive(1'b1, 32'hE2, 6'd0, 6'd0, 2'b11, 2'b01, 6'd0, 6'd7, 1'b1);
        chk("simul_sel_old", issue_payload_o, 32'hE0);
        step();
        idle(1'b0);
        chk("simul_count", 32'(count_o), 32'h2);
        chk("simul_wake_kept", issue_payload_o, 32'hE1);
        idle(1'b1);
        step(); step();
        chk("simul_empty", 32'(count_o), 32'h0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hF0 + 32'(i), 6'd20, 6'd20, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0); step();
        end
        chk("flush_pre_count", 32'(count_o), 32'h3);
        drive(1'b1, 32'hFF, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1);
        flush_i = 1'b1;
        step();
        idle(1'b0);
        chk("flush_count", 32'(count_o), 32'h0);
        chk("flush_valid", 32'(issue_valid_o), 32'h0);
        step();

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0); step();
        end
        idle(1'b0);
        chk("arst_pre_count", 32'(count_o), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 32'h0);
        chk("arst_valid", 32'(issue_valid_o), 32'h0);
        chk("arst_payload", issue_payload_o, 32'h0);
        chk("arst_disp_ready", 32'(disp_ready_o), 32'h1);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        repeat (400) begin
            drive(1'($urandom_range(0, 1)), $urandom,
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 2'($urandom),
                  2'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0));
            flush_i = ($urandom_range(0, 39) == 0);
            step();
        end
        idle(1'b1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
